// File: rtl/dmem_responder_if.sv
// dmem_responder_if: processor dmem port (word address, store data/strobe, registered read data)
interface dmem_responder_if;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    modport master (output address_dmem, data, wren, input q_dmem);
    modport slave (input address_dmem, data, wren, output q_dmem);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: falling-edge word RAM with read-first loads; define DMEM_RESPONDER_MMIO_EN
// to add the MMIO window (CYCLES, LED, STATUS, STORES) and sticky error reporting.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_F000
) (
    input  logic               clock,
    input  logic               reset,
    dmem_responder_if.slave    bus,
    output logic [31:0]        led_out,
    output logic               err_flag
);
    logic [31:0] ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic ram_we;
    logic [31:0] q_dmem_q, q_dmem_d;
    assign idx = bus.address_dmem[ADDR_WIDTH-1:0];
    assign bus.q_dmem = q_dmem_q;
    always_ff @(negedge clock)
        if (ram_we) ram[idx] <= bus.data;
    always_ff @(negedge clock or negedge reset)
        if (!reset) q_dmem_q <= '0;
        else q_dmem_q <= q_dmem_d;
`ifdef DMEM_RESPONDER_MMIO_EN
    logic is_ram, is_mmio, is_unm;
    logic [3:0] off;
    logic [31:0] mmio_rd;
    logic [31:0] cycles_q, cycles_d, stores_q, stores_d, led_q, led_d;
    logic [2:0] status_q, status_d;
    // status bits: {ro_write, unmapped_write, unmapped_read}
    always_comb begin
        off = bus.address_dmem[3:0];
        is_ram = (bus.address_dmem >> ADDR_WIDTH) == 32'd0;
        is_mmio = !is_ram && bus.address_dmem[31:4] == MMIO_BASE[31:4];
        is_unm = !is_ram && !is_mmio;
        ram_we = bus.wren && is_ram && reset;
        mmio_rd = off == 4'd0 ? cycles_q :
                  off == 4'd1 ? led_q :
                  off == 4'd2 ? {29'b0, status_q} :
                  off == 4'd3 ? stores_q : '0;
        q_dmem_d = is_ram ? ram[idx] : is_mmio ? mmio_rd : '0;
        cycles_d = cycles_q + 32'd1;
        stores_d = stores_q + 32'(ram_we);
        led_d = bus.wren && is_mmio && off == 4'd1 ? bus.data : led_q;
        status_d = bus.wren && is_mmio && off == 4'd2 ? 3'b000 :
                   status_q | {bus.wren && is_mmio && off != 4'd1, bus.wren && is_unm, !bus.wren && is_unm};
    end
    always_ff @(negedge clock or negedge reset)
        if (!reset) begin
            cycles_q <= '0;
            stores_q <= '0;
            led_q    <= '0;
            status_q <= '0;
        end else begin
            cycles_q <= cycles_d;
            stores_q <= stores_d;
            led_q    <= led_d;
            status_q <= status_d;
        end
    assign led_out = led_q;
    assign err_flag = |status_q;
`else
    logic unused_addr;
    assign unused_addr = ^{bus.address_dmem[31:ADDR_WIDTH], MMIO_BASE};
    always_comb begin
        ram_we = bus.wren && reset;
        q_dmem_d = ram[idx];
    end
    assign led_out = '0;
    assign err_flag = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table, async-reset sequence and random traffic vs a behavioural model
module tb_dmem_responder;
    logic clock, reset;
    logic [31:0] led_out;
    logic err_flag;
    int checks = 0, errors = 0;

    dmem_responder_if bus();
    dmem_responder dut (.clock(clock), .reset(reset), .bus(bus), .led_out(led_out), .err_flag(err_flag));

    initial clock = 1'b1;
    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] q;
        logic [31:0] led;
        logic        err;
    } vec_t;
    vec_t tbl[$];

    logic [31:0] mem [int unsigned];
    logic [31:0] m_cycles, m_stores, m_led;
    logic [2:0]  m_status;

    task automatic add(input logic wr, input logic [31:0] a, d, input logic c, input logic [31:0] q, led, input logic e);
        vec_t v;
        v = '{wr, a, d, c, q, led, e};
        tbl.push_back(v);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic access(input logic wr, input logic [31:0] a, d);
        bus.wren = wr;
        bus.address_dmem = a;
        bus.data = d;
        @(posedge clock);
    endtask

    task automatic model_reset();
        m_cycles = 0;
        m_stores = 0;
        m_led = 0;
        m_status = 0;
    endtask

    task automatic model_step(input logic wr, input logic [31:0] a, d, output logic known, output logic [31:0] eq);
        int unsigned k;
        logic is_ram, is_mmio;
        k = a % 4096;
`ifdef DMEM_RESPONDER_MMIO_EN
        is_ram = a < 4096;
        is_mmio = !is_ram && a[31:4] == 28'h0000F00;
`else
        is_ram = 1'b1;
        is_mmio = 1'b0;
`endif
        known = 1'b1;
        eq = 0;
        if (is_ram) begin
            known = mem.exists(k);
            if (known) eq = mem[k];
            if (wr) begin
                mem[k] = d;
                m_stores++;
            end
        end else if (is_mmio) begin
            case (a[3:0])
                4'd0: eq = m_cycles;
                4'd1: eq = m_led;
                4'd2: eq = {29'b0, m_status};
                4'd3: eq = m_stores;
                default: eq = 0;
            endcase
            if (wr) begin
                if (a[3:0] == 4'd1) m_led = d;
                else if (a[3:0] == 4'd2) m_status = 0;
                else m_status[2] = 1'b1;
            end
        end else if (wr) m_status[1] = 1'b1;
        else m_status[0] = 1'b1;
        m_cycles++;
    endtask

    task automatic step(input logic wr, input logic [31:0] a, d);
        logic known;
        logic [31:0] eq;
        model_step(wr, a, d, known, eq);
        access(wr, a, d);
        if (known) chk32($sformatf("rand q_dmem @%h", a), bus.q_dmem, eq);
        chk32("rand led_out", led_out, m_led);
        chk32("rand err_flag", {31'b0, err_flag}, {31'b0, m_status != 0});
    endtask

    initial begin
        logic [31:0] a;
`ifdef DMEM_RESPONDER_MMIO_EN
        add(0, 32'hF000, 0, 1, 32'h0, 0, 0);
        add(1, 32'h5, 32'hDEADBEEF, 0, 0, 0, 0);
        add(0, 32'h5, 0, 1, 32'hDEADBEEF, 0, 0);
        add(0, 32'hF003, 0, 1, 32'h1, 0, 0);
        add(1, 32'h7, 32'h11, 0, 0, 0, 0);
        add(1, 32'h7, 32'h22, 1, 32'h11, 0, 0);
        add(0, 32'h7, 0, 1, 32'h22, 0, 0);
        add(1, 32'hF001, 32'hA5, 1, 32'h0, 32'hA5, 0);
        add(0, 32'hF000, 0, 1, 32'd8, 32'hA5, 0);
        add(0, 32'hF000, 0, 1, 32'd9, 32'hA5, 0);
        add(0, 32'h8000, 0, 1, 32'h0, 32'hA5, 1);
        add(0, 32'hF002, 0, 1, 32'h1, 32'hA5, 1);
        add(1, 32'hF000, 32'h1234, 1, 32'd12, 32'hA5, 1);
        add(0, 32'hF002, 0, 1, 32'h5, 32'hA5, 1);
        add(1, 32'hF002, 32'hFFFFFFFF, 1, 32'h5, 32'hA5, 0);
        add(0, 32'hF002, 0, 1, 32'h0, 32'hA5, 0);
        add(1, 32'h9000, 32'h1, 1, 32'h0, 32'hA5, 1);
        add(0, 32'hF002, 0, 1, 32'h2, 32'hA5, 1);
        add(1, 32'hF005, 32'h7, 1, 32'h0, 32'hA5, 1);
        add(0, 32'hF002, 0, 1, 32'h6, 32'hA5, 1);
        add(1, 32'hF002, 32'h0, 1, 32'h6, 32'hA5, 0);
        add(0, 32'hF003, 0, 1, 32'h3, 32'hA5, 0);
        add(0, 32'hF001, 0, 1, 32'hA5, 32'hA5, 0);
`else
        add(1, 32'h5, 32'hDEADBEEF, 0, 0, 0, 0);
        add(0, 32'h5, 0, 1, 32'hDEADBEEF, 0, 0);
        add(1, 32'h1005, 32'h33, 1, 32'hDEADBEEF, 0, 0);
        add(0, 32'h5, 0, 1, 32'h33, 0, 0);
        add(1, 32'h7, 32'h11, 0, 0, 0, 0);
        add(1, 32'h7, 32'h22, 1, 32'h11, 0, 0);
        add(0, 32'hFFFFF007, 0, 1, 32'h22, 0, 0);
        add(0, 32'h8000, 0, 0, 0, 0, 0);
`endif
        reset = 1'b0;
        bus.wren = 1'b0;
        bus.address_dmem = 0;
        bus.data = 0;
        repeat (3) @(posedge clock);
        chk32("reset q_dmem", bus.q_dmem, 0);
        chk32("reset led_out", led_out, 0);
        chk32("reset err_flag", {31'b0, err_flag}, 0);
        reset = 1'b1;
        foreach (tbl[i]) begin
            access(tbl[i].wr, tbl[i].addr, tbl[i].data);
            if (tbl[i].chk) chk32($sformatf("row%0d q_dmem", i), bus.q_dmem, tbl[i].q);
            chk32($sformatf("row%0d led_out", i), led_out, tbl[i].led);
            chk32($sformatf("row%0d err_flag", i), {31'b0, err_flag}, {31'b0, tbl[i].err});
        end

        reset = 1'b0;
        bus.wren = 1'b0;
        @(posedge clock);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 64; i++) step(1'b1, i, $urandom);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0, 1: a = $urandom_range(0, 63);
                2: a = 32'hF000 + $urandom_range(0, 15);
                default: a = $urandom_range(0, 1) ? 32'h8000 + $urandom_range(0, 63) : $urandom;
            endcase
            step(1'($urandom_range(0, 1)), a, $urandom);
        end

        step(1'b1, 32'hF001, 32'h5A5A_0001);
        bus.wren = 1'b1;
        bus.address_dmem = 32'h9;
        bus.data = 32'hBAD0_0009;
        #2 reset = 1'b0;
        #1;
        chk32("async reset q_dmem", bus.q_dmem, 0);
        chk32("async reset led_out", led_out, 0);
        chk32("async reset err_flag", {31'b0, err_flag}, 0);
        @(posedge clock);
        bus.wren = 1'b0;
        reset = 1'b1;
        model_reset();
        step(1'b0, 32'hF000, 0);
        step(1'b0, 32'h9, 0);
        step(1'b0, 32'hF003, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the processor's dmem port (`address_dmem`, `data`, `wren` → `q_dmem`). It holds a word-addressed RAM and a small memory-mapped I/O window with a cycle counter, an LED register, sticky error status and a store counter. It sits in the wrapper between the processor and the board I/O and replaces the bare RAM instance.

## Interface

Parameters:
- `ADDR_WIDTH`, default 12: RAM depth is 2^ADDR_WIDTH 32-bit words.
- `MMIO_BASE`, default 32'h0000_F000: base word address of the MMIO window (16 words; low 4 bits must be 0).

Ports:
- `clock`, input, 1: master clock; all state updates on the falling edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `address_dmem`, input, 32: word address from processor XM stage.
- `data`, input, 32: store data.
- `wren`, input, 1: store strobe, one access per cycle.
- `q_dmem`, output, 32: read data (registered).
- `led_out`, output, 32: LED register contents.
- `err_flag`, output, 1: OR of the sticky status bits.

## Operation

- Decode of `address_dmem`:
  - RAM when `address_dmem < 2^ADDR_WIDTH`.
  - MMIO when `address_dmem[31:4] == MMIO_BASE[31:4]`.
  - Otherwise unmapped.
- RAM:
  - Store: `wren=1` writes `data` to `ram[address_dmem[ADDR_WIDTH-1:0]]`.
  - Load: `q_dmem` gets the word.
  - RAM contents are not reset.
- MMIO offsets (`address_dmem[3:0]`):
  - 0 `CYCLES`: read-only free-running counter. Increments every falling edge and wraps at 2^32.
  - 1 `LED`: read/write. Drives `led_out`.
  - 2 `STATUS`: read returns {29'b0, ro_write, unmapped_write, unmapped_read}. Any write clears all three bits; the write itself records no error.
  - 3 `STORES`: read-only count of successful RAM stores. Wraps at 2^32.
  - 4–15: reserved. Reads return 0. Writes set `ro_write`.
- Errors (sticky until a STATUS write or reset):
  - Unmapped load sets `unmapped_read` and returns 0.
  - Unmapped store sets `unmapped_write` and modifies nothing.
  - Store to `CYCLES`, `STORES` or reserved offsets sets `ro_write` and modifies nothing.
- `q_dmem` updates on every falling edge, including store cycles. On a store it returns the pre-write contents of the addressed location (read-first).
- `err_flag` is combinational from the status register.
- Reset values:
  - `q_dmem` = 0, `led_out` = 0, `err_flag` = 0.
  - CYCLES = 0, STORES = 0, STATUS = 0.
- Reset asserted mid-operation: all registers above clear immediately. A store in that cycle is dropped. RAM keeps its contents.

## Timing

- Address and `wren` are sampled at the falling edge following the processor's rising-edge XM update.
- `q_dmem` is valid half a cycle after the address is presented, so it is stable at the next rising edge, when the processor's MW latch captures it. Effective latency is 0 processor cycles.
- A store is visible to a load of the same address presented in the next cycle.
- `CYCLES` read returns the value held before that edge's increment. Two back-to-back reads differ by exactly 1.
- `STORES` increments on the same edge as the RAM write. A read of `STORES` in the following cycle reflects it.
- `led_out` updates at the falling edge of the store cycle.
- First falling edge after reset deassertion is the first sampled access. CYCLES reads 0 there.

## Configuration

- Macro: `DMEM_RESPONDER_MMIO_EN`.
- Defined: MMIO window, status bits and `err_flag` behave as above.
- Not defined:
  - No MMIO and no error logic.
  - All addresses map to RAM modulo 2^ADDR_WIDTH (upper bits ignored).
  - `led_out` and `err_flag` are tied to 0.

## Test plan

- Reset/idle: hold `reset`=0, then release → `q_dmem`=0, `led_out`=0, `err_flag`=0. Load of 0xF000 on the first edge → 0.
- RAM store/load: store 0xDEADBEEF to addr 5. Next cycle load 5 → `q_dmem`=0xDEADBEEF. Load 0xF003 → 1.
- Read-first: store 0x11 to addr 7, then store 0x22 to addr 7 → `q_dmem` during the second store = 0x11. Following load → 0x22.
- MMIO: store 0xA5 to 0xF001 → `led_out`=0xA5 after that falling edge. Two consecutive loads of 0xF000 differ by 1.
- Errors:
  - Load 0x8000 → 0, `err_flag`=1, STATUS reads 1.
  - Store to 0xF000 → STATUS=5.
  - Store any value to 0xF002 → STATUS=0, `err_flag`=0.
- Without macro: ADDR_WIDTH=12, store 0x33 to 0x1005, load 0x0005 → 0x33. `err_flag` stays 0.
